// File: rtl/cache_sa_plru_wb_pkg.sv
// rtl/cache_sa_plru_wb_pkg.sv - shared state codes, width helpers and line metadata for the cache
package cache_sa_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPARE = 3'd1;
  localparam logic [2:0] S_WB      = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Tags are stored zero-extended to this width so the struct is parameter independent.
  localparam int TAG_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int words, input int sets);
    return addr_w - $clog2(words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_sa_plru_wb_if.sv
// rtl/cache_sa_plru_wb_if.sv - CPU word port and block-wide memory port of the cache
interface cache_sa_plru_wb_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 16,
  parameter int WORDS  = 4
);
  logic                      i_req;
  logic                      i_w;
  logic [ADDR_W-1:0]         i_address;
  logic [WORD_W-1:0]         i_data;
  logic                      o_ready;
  logic                      o_valid;
  logic [WORD_W-1:0]         o_data;
  logic                      o_mem_req;
  logic                      o_mem_w;
  logic [ADDR_W-1:0]         o_mem_address;
  logic [WORDS*WORD_W-1:0]   o_mem_wdata;
  logic                      i_mem_ack;
  logic [WORDS*WORD_W-1:0]   i_mem_rdata;

  modport slave (
    input  i_req, i_w, i_address, i_data, i_mem_ack, i_mem_rdata,
    output o_ready, o_valid, o_data, o_mem_req, o_mem_w, o_mem_address, o_mem_wdata
  );

  modport master (
    output i_req, i_w, i_address, i_data, i_mem_ack, i_mem_rdata,
    input  o_ready, o_valid, o_data, o_mem_req, o_mem_w, o_mem_address, o_mem_wdata
  );
endinterface

// File: rtl/cache_sa_plru_wb_plru.sv
// rtl/cache_sa_plru_wb_plru.sv - tree pseudo-LRU victim walk and access update (heap-ordered nodes)
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         tree_bits,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [$clog2(WAYS)-1:0] victim_way,
  output logic [WAYS-2:0]         next_bits
);
  localparam int WAY_W = $clog2(WAYS);

  // Node n has children 2n+1 (lower half) and 2n+2 (upper half); bit 1 steers to the upper half.
  always_comb begin : victim_walk
    int   node;
    logic dir;
    node       = 0;
    dir        = 1'b0;
    victim_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) dir = tree_bits[n];
      end
      victim_way[WAY_W-1-l] = dir;
      node = 2 * node + 1 + (dir ? 1 : 0);
    end
  end

  always_comb begin : access_update
    int   node;
    logic dir;
    node      = 0;
    dir       = 1'b0;
    next_bits = tree_bits;
    for (int l = 0; l < WAY_W; l++) begin
      dir = access_way[WAY_W-1-l];
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) next_bits[n] = ~dir;
      end
      node = 2 * node + 1 + (dir ? 1 : 0);
    end
  end
endmodule

// File: rtl/cache_sa_plru_wb.sv
// rtl/cache_sa_plru_wb.sv - set-associative write-back write-allocate cache with tree PLRU and memory fill/write-back
module cache_sa_plru_wb
  import cache_sa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 16,
  parameter int WORDS  = 4,
  parameter int SETS   = 256,
  parameter int WAYS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_sa_plru_wb_if.slave bus
);
  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, WORDS, SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef logic [WORDS-1:0][WORD_W-1:0] blk_t;

  logic [2:0]        state_q, state_d;
  logic              req_w_q, req_w_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  blk_t              mem_wdata_q, mem_wdata_d;

  blk_t              data_q [SETS][WAYS];
  line_meta_t        meta_q [SETS][WAYS];
  logic [WAYS-2:0]   plru_q [SETS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  logic              hit, has_inv;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_victim, victim_sel, acc_way;
  logic [WAYS-2:0]   plru_next;
  line_meta_t        vmeta;

  logic              data_we, meta_we, plru_we;
  logic [WAY_W-1:0]  data_way, meta_way;
  blk_t              data_wblk;
  line_meta_t        meta_wval;

  assign off = req_addr_q[OFF_W-1:0];
  assign idx = req_addr_q[OFF_W +: IDX_W];
  assign tag = req_addr_q[ADDR_W-1 -: TAG_W];

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_valid       = valid_q;
  assign bus.o_data        = rdata_q;
  assign bus.o_mem_req     = mem_req_q;
  assign bus.o_mem_w       = mem_w_q;
  assign bus.o_mem_address = mem_addr_q;
  assign bus.o_mem_wdata   = mem_wdata_q;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree_bits  (plru_q[idx]),
    .access_way (acc_way),
    .victim_way (plru_victim),
    .next_bits  (plru_next)
  );

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (meta_q[idx][w].valid && meta_q[idx][w].tag == TAG_MAX_W'(tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!meta_q[idx][w].valid) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim_sel = has_inv ? inv_way : plru_victim;
    vmeta      = meta_q[idx][victim_sel];
  end

  always_comb begin
    blk_t blk;
    state_d     = state_q;
    req_w_d     = req_w_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    valid_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_w_d     = mem_w_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_way    = hit_way;
    data_wblk   = data_q[idx][hit_way];
    meta_we     = 1'b0;
    meta_way    = hit_way;
    meta_wval   = meta_q[idx][hit_way];
    plru_we     = 1'b0;
    acc_way     = hit_way;
    blk         = data_q[idx][hit_way];

    case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          req_w_d     = bus.i_w;
          req_addr_d  = bus.i_address;
          req_wdata_d = bus.i_data;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          plru_we = 1'b1;
          valid_d = 1'b1;
          state_d = S_IDLE;
          if (req_w_q) begin
            blk[off]        = req_wdata_q;
            data_we         = 1'b1;
            data_wblk       = blk;
            meta_we         = 1'b1;
            meta_wval.dirty = 1'b1;
          end else begin
            rdata_d = blk[off];
          end
        end else begin
          victim_d  = victim_sel;
          mem_req_d = 1'b1;
          if (vmeta.valid && vmeta.dirty) begin
            state_d     = S_WB;
            mem_w_d     = 1'b1;
            mem_addr_d  = ADDR_W'({vmeta.tag, idx, {OFF_W{1'b0}}});
            mem_wdata_d = data_q[idx][victim_sel];
          end else begin
            state_d    = S_FILL;
            mem_w_d    = 1'b0;
            mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
          end
        end
      end
      S_WB: begin
        if (mem_req_q && bus.i_mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        // Entered with the request low after a write-back; raise it one cycle later.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_w_d    = 1'b0;
          mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
        end else if (bus.i_mem_ack) begin
          mem_req_d       = 1'b0;
          data_we         = 1'b1;
          data_way        = victim_q;
          data_wblk       = bus.i_mem_rdata;
          meta_we         = 1'b1;
          meta_way        = victim_q;
          meta_wval.valid = 1'b1;
          meta_wval.dirty = 1'b0;
          meta_wval.tag   = TAG_MAX_W'(tag);
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        blk      = data_q[idx][victim_q];
        acc_way  = victim_q;
        plru_we  = 1'b1;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
        if (req_w_q) begin
          blk[off]        = req_wdata_q;
          data_we         = 1'b1;
          data_way        = victim_q;
          data_wblk       = blk;
          meta_we         = 1'b1;
          meta_way        = victim_q;
          meta_wval       = meta_q[idx][victim_q];
          meta_wval.dirty = 1'b1;
        end else begin
          rdata_d = blk[off];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_w_q     <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_w_q     <= req_w_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta_q[s][w].valid <= 1'b0;
          meta_q[s][w].dirty <= 1'b0;
        end
        plru_q[s] <= '0;
      end
    end else begin
      if (meta_we) meta_q[idx][meta_way] <= meta_wval;
      if (plru_we) plru_q[idx] <= plru_next;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[idx][data_way] <= data_wblk;
  end
endmodule

// File: tb/tb_cache_sa_plru_wb.sv
// tb/tb_cache_sa_plru_wb.sv - directed self-checking bench for cache_sa_plru_wb
module tb_cache_sa_plru_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  cache_sa_plru_wb_if #(.ADDR_W(32), .WORD_W(16), .WORDS(4)) bus ();

  cache_sa_plru_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] d);
    int n = 0;
    while (!bus.o_ready && n < 50) begin step(); n++; end
    bus.i_req = 1'b1; bus.i_w = w; bus.i_address = a; bus.i_data = d;
    step();
    bus.i_req = 1'b0;
    chk("ready_low_after_accept", 64'(bus.o_ready), 64'(0));
  endtask

  task automatic mem_serve(input string tag, input logic w, input logic [31:0] a,
                           input logic [63:0] wd, input logic [63:0] rd, input int delay);
    int n = 0;
    while (!bus.o_mem_req && n < 50) begin step(); n++; end
    chk({tag, "_req"}, 64'(bus.o_mem_req), 64'(1));
    chk({tag, "_w"}, 64'(bus.o_mem_w), 64'(w));
    chk({tag, "_addr"}, 64'(bus.o_mem_address), 64'(a));
    if (w) chk({tag, "_wdata"}, bus.o_mem_wdata, wd);
    repeat (delay) step();
    if (delay > 0) chk({tag, "_hold"}, 64'(bus.o_mem_address), 64'(a));
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = rd;
    step();
    bus.i_mem_ack = 1'b0;
    chk({tag, "_drop"}, 64'(bus.o_mem_req), 64'(0));
  endtask

  task automatic wait_valid(input string tag, input logic rd, input logic [15:0] exp);
    int n = 0;
    while (!bus.o_valid && n < 50) begin step(); n++; end
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'(1));
    if (rd) chk({tag, "_data"}, 64'(bus.o_data), 64'(exp));
    step();
    chk({tag, "_pulse"}, 64'(bus.o_valid), 64'(0));
  endtask

  task automatic hit(input string tag, input logic w, input logic [31:0] a,
                     input logic [15:0] d, input logic [15:0] exp);
    issue(w, a, d);
    chk({tag, "_valid_early"}, 64'(bus.o_valid), 64'(0));
    step();
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'(1));
    chk({tag, "_ready"}, 64'(bus.o_ready), 64'(1));
    chk({tag, "_nomem"}, 64'(bus.o_mem_req), 64'(0));
    if (!w) chk({tag, "_data"}, 64'(bus.o_data), 64'(exp));
  endtask

  task automatic read_fill(input string tag, input logic [31:0] a, input logic [63:0] rd,
                           input logic [15:0] exp);
    issue(1'b0, a, 16'h0);
    mem_serve(tag, 1'b0, a & ~32'h3, 64'h0, rd, 0);
    wait_valid(tag, 1'b1, exp);
  endtask

  initial begin
    logic [63:0] rd;
    logic [31:0] a;
    bus.i_req = 1'b0; bus.i_w = 1'b0; bus.i_address = '0; bus.i_data = '0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_ready", 64'(bus.o_ready), 64'(1));
    chk("rst_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_data", 64'(bus.o_data), 64'(0));
    chk("rst_mem_req", 64'(bus.o_mem_req), 64'(0));
    chk("rst_mem_w", 64'(bus.o_mem_w), 64'(0));
    chk("rst_mem_addr", 64'(bus.o_mem_address), 64'(0));

    issue(1'b0, 32'h5, 16'h0);
    mem_serve("fill4", 1'b0, 32'h4, 64'h0, 64'h000D_000C_000B_000A, 2);
    wait_valid("rd5_miss", 1'b1, 16'h000B);

    hit("rd5_hit", 1'b0, 32'h5, 16'h0, 16'h000B);
    hit("wr4_hit", 1'b1, 32'h4, 16'h1234, 16'h0);
    hit("rd4_hit", 1'b0, 32'h4, 16'h0, 16'h1234);

    for (int k = 1; k <= 3; k++) begin
      a  = 32'(k * 32'h400 + 4);
      rd = {16'(k * 256 + 3), 16'(k * 256 + 2), 16'(k * 256 + 1), 16'(k * 256)};
      read_fill("fill_set1", a, rd, 16'(k * 256));
    end

    issue(1'b0, 32'h1004, 16'h0);
    mem_serve("wb4", 1'b1, 32'h4, 64'h000D_000C_000B_1234, 64'h0, 1);
    step();
    chk("wb_gap_rereq", 64'(bus.o_mem_req), 64'(1));
    mem_serve("fill1004", 1'b0, 32'h1004, 64'h0, 64'h0044_0033_0022_0011, 0);
    wait_valid("rd1004", 1'b1, 16'h0011);

    issue(1'b1, 32'h8, 16'hBEEF);
    mem_serve("fill8", 1'b0, 32'h8, 64'h0, 64'h0A03_0A02_0A01_0A00, 0);
    wait_valid("wr8_miss", 1'b0, 16'h0);
    hit("rd9_hit", 1'b0, 32'h9, 16'h0, 16'h0A01);
    hit("rd8_hit", 1'b0, 32'h8, 16'h0, 16'hBEEF);
    for (int k = 1; k <= 3; k++) begin
      a  = 32'(k * 32'h400 + 8);
      rd = {16'(k * 256 + 3), 16'(k * 256 + 2), 16'(k * 256 + 1), 16'(k * 256)};
      read_fill("fill_set2", a, rd, 16'(k * 256));
    end
    issue(1'b0, 32'h100A, 16'h0);
    mem_serve("wb8", 1'b1, 32'h8, 64'h0A03_0A02_0A01_BEEF, 64'h0, 0);
    step();
    chk("wb8_gap_rereq", 64'(bus.o_mem_req), 64'(1));
    mem_serve("fill1008", 1'b0, 32'h1008, 64'h0, 64'h5503_5502_5501_5500, 0);
    wait_valid("rd100a", 1'b1, 16'h5502);

    issue(1'b0, 32'h30, 16'h0);
    step();
    chk("mid_fill_req", 64'(bus.o_mem_req), 64'(1));
    chk("mid_fill_w", 64'(bus.o_mem_w), 64'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_mem_req", 64'(bus.o_mem_req), 64'(0));
    chk("abort_ready", 64'(bus.o_ready), 64'(1));
    chk("abort_valid", 64'(bus.o_valid), 64'(0));
    step();
    chk("abort_no_valid", 64'(bus.o_valid), 64'(0));

    read_fill("refill30", 32'h30, 64'h0C33_0C32_0C31_0C30, 16'h0C30);
    read_fill("refill4", 32'h6, 64'h7703_7702_7701_7700, 16'h7702);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
